// File: rtl/clock_switch_sequencer.sv
// Sequences DCM reset, lock wait and clock-mux selection around clock-presence changes.
// Registered FSM with lock-timeout fault reporting and a saturating switch counter.
module clock_switch_sequencer #(
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk1_present,
  input  logic       switching,
  input  logic       dcm_locked,
  input  logic       fault_clear,
  output logic       clk_sel,
  output logic       dcm_reset,
  output logic       ready,
  output logic       lock_fault,
  output logic [7:0] switch_count
);

  typedef enum logic [1:0] {RST_HOLD, WAIT_LOCK, RUN, PEND} state_t;

  localparam logic [7:0]  HOLD_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(LOCK_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  hold_cnt, hold_cnt_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        lock_meta, lock_sync;
  logic        lock_low, lock_low_nxt;
  logic        timeout;
  logic        clk_sel_nxt, dcm_reset_nxt, ready_nxt, lock_fault_nxt;
  logic [7:0]  switch_count_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RST_HOLD;
      hold_cnt     <= '0;
      wait_cnt     <= '0;
      lock_meta    <= 1'b0;
      lock_sync    <= 1'b0;
      lock_low     <= 1'b0;
      clk_sel      <= 1'b0;
      dcm_reset    <= 1'b1;
      ready        <= 1'b0;
      lock_fault   <= 1'b0;
      switch_count <= '0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_cnt_nxt;
      wait_cnt     <= wait_cnt_nxt;
      lock_meta    <= dcm_locked;
      lock_sync    <= lock_meta;
      lock_low     <= lock_low_nxt;
      clk_sel      <= clk_sel_nxt;
      dcm_reset    <= dcm_reset_nxt;
      ready        <= ready_nxt;
      lock_fault   <= lock_fault_nxt;
      switch_count <= switch_count_nxt;
    end
  end

  // Switching always wins, so a presence change is never lost behind a lock event.
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    unique case (state)
      RST_HOLD: begin
        if (switching)                state_nxt = PEND;
        else if (hold_cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (switching)      state_nxt = PEND;
        else if (lock_sync) state_nxt = RUN;
        else if (wait_cnt == WAIT_LAST) begin
          state_nxt = RST_HOLD;
          timeout   = 1'b1;
        end
      end
      RUN: begin
        if (switching)                  state_nxt = PEND;
        else if (!lock_sync && lock_low) state_nxt = RST_HOLD;
      end
      PEND: begin
        if (!switching) state_nxt = RST_HOLD;
      end
      default: state_nxt = RST_HOLD;
    endcase
  end

  always_comb begin
    hold_cnt_nxt  = (state == RST_HOLD && state_nxt == RST_HOLD) ? hold_cnt + 8'd1 : '0;
    wait_cnt_nxt  = (state == WAIT_LOCK && state_nxt == WAIT_LOCK) ? wait_cnt + 16'd1 : '0;
    lock_low_nxt  = (state == RUN && state_nxt == RUN) ? !lock_sync : 1'b0;
    dcm_reset_nxt = (state_nxt == RST_HOLD) || (state_nxt == PEND);
    ready_nxt     = (state_nxt == RUN);

    clk_sel_nxt = clk_sel;
    if (timeout)
      clk_sel_nxt = 1'b0;
    else if (state == PEND && !switching)
      clk_sel_nxt = clk1_present;

    lock_fault_nxt = lock_fault;
    if (timeout)
      lock_fault_nxt = 1'b1;
    else if (fault_clear)
      lock_fault_nxt = 1'b0;

    switch_count_nxt = switch_count;
    if (clk_sel_nxt != clk_sel && switch_count != 8'hFF)
      switch_count_nxt = switch_count + 8'd1;
  end

endmodule

// File: tb/tb_clock_switch_sequencer.sv
// Bench for clock_switch_sequencer: directed vector table, corner sequences and
// randomized stimulus against a cycle-stepped behavioural model.
module tb_clock_switch_sequencer;

  localparam int RC = 16;
  localparam int LT = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk1_present = 1'b0;
  logic       switching = 1'b0;
  logic       dcm_locked = 1'b1;
  logic       fault_clear = 1'b0;
  logic       clk_sel, dcm_reset, ready, lock_fault;
  logic [7:0] switch_count;

  clock_switch_sequencer #(.RESET_CYCLES(RC), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset(reset), .clk1_present(clk1_present), .switching(switching),
    .dcm_locked(dcm_locked), .fault_clear(fault_clear), .clk_sel(clk_sel),
    .dcm_reset(dcm_reset), .ready(ready), .lock_fault(lock_fault),
    .switch_count(switch_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: phase name, absolute start times, lock history queue.
  int    cyc = 0;
  string ph = "hold";
  int    hold_start, wait_start, low_run;
  bit    e_sel, e_rst = 1'b1, e_rdy, e_flt;
  int    e_cnt;
  bit    lk_hist[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    bit lk, to, nsel;
    cyc++;
    if (reset) begin
      ph = "hold"; hold_start = cyc + 1;
      e_sel = 1'b0; e_cnt = 0; e_flt = 1'b0;
      lk_hist = '{1'b0, 1'b0};
    end else begin
      lk = lk_hist[0]; to = 1'b0; nsel = e_sel;
      if (ph == "hold") begin
        if (switching) ph = "pend";
        else if (cyc - hold_start + 1 == RC) begin ph = "wait"; wait_start = cyc + 1; end
      end else if (ph == "wait") begin
        if (switching) ph = "pend";
        else if (lk) begin ph = "run"; low_run = 0; end
        else if (cyc - wait_start + 1 == LT) begin
          to = 1'b1; ph = "hold"; hold_start = cyc + 1;
        end
      end else if (ph == "run") begin
        if (switching) ph = "pend";
        else if (!lk) begin
          low_run++;
          if (low_run == 2) begin ph = "hold"; hold_start = cyc + 1; end
        end else low_run = 0;
      end else begin
        if (!switching) begin nsel = clk1_present; ph = "hold"; hold_start = cyc + 1; end
      end
      if (to) begin nsel = 1'b0; e_flt = 1'b1; end
      else if (fault_clear) e_flt = 1'b0;
      if (nsel != e_sel && e_cnt < 255) e_cnt++;
      e_sel = nsel;
      lk_hist.push_back(dcm_locked);
      void'(lk_hist.pop_front());
    end
    e_rst = (ph == "hold" || ph == "pend");
    e_rdy = (ph == "run");
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model clk_sel", int'(clk_sel), int'(e_sel));
    check("model dcm_reset", int'(dcm_reset), int'(e_rst));
    check("model ready", int'(ready), int'(e_rdy));
    check("model lock_fault", int'(lock_fault), int'(e_flt));
    check("model switch_count", int'(switch_count), e_cnt);
  endtask

  task automatic pulse(input bit c);
    clk1_present = c; switching = 1'b1; step();
    switching = 1'b0; step();
  endtask

  typedef struct {
    bit rst, c1p, sw, lk, fc;
    int n;
    bit x_sel, x_rst, x_rdy, x_flt;
    int x_cnt;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, c1p, sw, lk, fc, input int n,
                     input bit xs, xr, xy, xf, input int xc, input string nm);
    vec_t v;
    v.rst = rst; v.c1p = c1p; v.sw = sw; v.lk = lk; v.fc = fc; v.n = n;
    v.x_sel = xs; v.x_rst = xr; v.x_rdy = xy; v.x_flt = xf; v.x_cnt = xc; v.name = nm;
    vecs.push_back(v);
  endtask

  int sw_left = 0;

  initial begin
    //  rst c1p sw lk fc  n   sel rst rdy flt cnt
    add(1, 0, 0, 1, 0,  3,  0, 1, 0, 0, 0, "reset_state");
    add(0, 0, 0, 1, 0, 15,  0, 1, 0, 0, 0, "hold_15");
    add(0, 0, 0, 1, 0,  1,  0, 0, 0, 0, 0, "hold_end");
    add(0, 0, 0, 1, 0,  1,  0, 0, 1, 0, 0, "first_lock");
    add(0, 1, 1, 1, 0,  1,  0, 1, 0, 0, 0, "sw_rise");
    add(0, 1, 1, 1, 0,  3,  0, 1, 0, 0, 0, "sw_held");
    add(0, 1, 0, 1, 0,  1,  1, 1, 0, 0, 1, "sw_fall");
    add(0, 1, 0, 1, 0, 15,  1, 1, 0, 0, 1, "sw_hold15");
    add(0, 1, 0, 1, 0,  1,  1, 0, 0, 0, 1, "sw_hold_end");
    add(0, 1, 0, 1, 0,  1,  1, 0, 1, 0, 1, "sw_relock");
    add(0, 1, 0, 0, 0,  1,  1, 0, 1, 0, 1, "glitch_low");
    add(0, 1, 0, 1, 0,  4,  1, 0, 1, 0, 1, "glitch_ignored");
    add(0, 1, 0, 0, 0,  2,  1, 0, 1, 0, 1, "loss_2");
    add(0, 1, 0, 1, 0,  1,  1, 0, 1, 0, 1, "loss_sync1");
    add(0, 1, 0, 1, 0,  1,  1, 1, 0, 0, 1, "loss_exit");
    add(0, 1, 0, 1, 0, 15,  1, 1, 0, 0, 1, "loss_hold15");
    add(0, 1, 0, 1, 0,  1,  1, 0, 0, 0, 1, "loss_hold_end");
    add(0, 1, 0, 1, 0,  1,  1, 0, 1, 0, 1, "loss_relock");
    add(0, 1, 0, 0, 0,  4,  1, 1, 0, 0, 1, "drop_ext");
    add(0, 1, 0, 0, 0, 16,  1, 0, 0, 0, 1, "wait_start");
    add(0, 1, 0, 0, 0, 99,  1, 0, 0, 0, 1, "wait_99");
    add(0, 1, 0, 0, 0,  1,  0, 1, 0, 1, 2, "timeout_ext");
    add(0, 1, 0, 1, 0, 16,  0, 0, 0, 1, 2, "int_wait");
    add(0, 1, 0, 1, 0,  1,  0, 0, 1, 1, 2, "int_relock");
    add(0, 1, 0, 0, 0,  4,  0, 1, 0, 1, 2, "drop_int");
    add(0, 1, 0, 0, 0, 16,  0, 0, 0, 1, 2, "wait2_start");
    add(0, 1, 0, 0, 0, 99,  0, 0, 0, 1, 2, "wait2_99");
    add(0, 1, 0, 0, 1,  1,  0, 1, 0, 1, 2, "timeout_with_clear");
    add(0, 1, 0, 0, 0,  5,  0, 1, 0, 1, 2, "fault_sticky");
    add(0, 1, 0, 0, 1,  1,  0, 1, 0, 0, 2, "fault_clear");
    add(0, 1, 0, 0, 0,  1,  0, 1, 0, 0, 2, "fault_stays_clear");

    foreach (vecs[i]) begin
      reset = vecs[i].rst; clk1_present = vecs[i].c1p; switching = vecs[i].sw;
      dcm_locked = vecs[i].lk; fault_clear = vecs[i].fc;
      for (int k = 0; k < vecs[i].n; k++) step();
      check({vecs[i].name, " clk_sel"}, int'(clk_sel), int'(vecs[i].x_sel));
      check({vecs[i].name, " dcm_reset"}, int'(dcm_reset), int'(vecs[i].x_rst));
      check({vecs[i].name, " ready"}, int'(ready), int'(vecs[i].x_rdy));
      check({vecs[i].name, " lock_fault"}, int'(lock_fault), int'(vecs[i].x_flt));
      check({vecs[i].name, " switch_count"}, int'(switch_count), vecs[i].x_cnt);
    end
    fault_clear = 1'b0;

    // Reset during WAIT_LOCK with external clock selected and five switches recorded.
    pulse(1'b1); pulse(1'b0); pulse(1'b1);
    for (int k = 0; k < RC + 5; k++) step();
    check("prereset clk_sel", int'(clk_sel), 1);
    check("prereset dcm_reset", int'(dcm_reset), 0);
    check("prereset switch_count", int'(switch_count), 5);
    reset = 1'b1; step();
    check("midreset clk_sel", int'(clk_sel), 0);
    check("midreset switch_count", int'(switch_count), 0);
    check("midreset dcm_reset", int'(dcm_reset), 1);
    check("midreset lock_fault", int'(lock_fault), 0);
    check("midreset ready", int'(ready), 0);
    reset = 1'b0;

    // Saturation of the switch counter.
    for (int i = 0; i < 260; i++) pulse(i % 2 == 0);
    check("saturate switch_count", int'(switch_count), 255);
    check("saturate clk_sel", int'(clk_sel), 0);

    dcm_locked = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      if (sw_left > 0) begin
        switching = 1'b1; sw_left--;
      end else begin
        switching = 1'b0;
        if ($urandom_range(0, 39) == 0) sw_left = $urandom_range(1, 5);
      end
      if ($urandom_range(0, 59) == 0) dcm_locked = ~dcm_locked;
      if ($urandom_range(0, 29) == 0) clk1_present = ~clk1_present;
      fault_clear = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
